// File: rtl/trigger_pulse_shaper.sv
// Trigger pulse shaper: turns each accepted rising edge of output_trigger into a
// delayed, width-controlled pulse followed by a holdoff, with accepted/missed counters.
module trigger_pulse_shaper #(
  parameter int CNT_W      = 16,
  parameter int TRIG_CNT_W = 32,
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  scen_reset,
  input  logic                  enable,
  input  logic                  output_trigger,
  input  logic [CNT_W-1:0]      delay_cycles,
  input  logic [CNT_W-1:0]      width_cycles,
  input  logic [CNT_W-1:0]      holdoff_cycles,
  input  logic                  count_clear,
  output logic                  trig_out,
  output logic                  busy,
  output logic [TRIG_CNT_W-1:0] trig_count,
  output logic [MISS_CNT_W-1:0] missed_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TRIG_CNT_W-1:0] TRIG_ONE = {{(TRIG_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [MISS_CNT_W-1:0] MISS_ONE = {{(MISS_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [MISS_CNT_W-1:0] MISS_MAX = {MISS_CNT_W{1'b1}};

  // A programmed width of zero still produces a one-cycle pulse.
  function automatic logic [CNT_W-1:0] last_pulse_index(input logic [CNT_W-1:0] w);
    if (w == CNT_ZERO) begin
      return CNT_ZERO;
    end else begin
      return w - CNT_ONE;
    end
  endfunction

  state_t           state_r;
  logic             prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] width_sh_r;
  logic [CNT_W-1:0] holdoff_sh_r;
  logic             rise_s;
  logic             accept_s;
  logic             missed_s;
  logic             enter_pulse_s;

  // Edge detection and per-state accept/miss/pulse-entry decode.
  always_comb begin
    rise_s        = output_trigger & ~prev_r;
    accept_s      = 1'b0;
    missed_s      = 1'b0;
    enter_pulse_s = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s      = rise_s & enable;
        enter_pulse_s = rise_s & enable & (delay_cycles == CNT_ZERO);
      end
      DELAY: begin
        missed_s      = rise_s & enable;
        enter_pulse_s = (cnt_r == CNT_ZERO);
      end
      PULSE:   missed_s = rise_s & enable;
      HOLDOFF: missed_s = rise_s & enable;
      default: missed_s = 1'b0;
    endcase
  end

  // Sequencer: edge register, shadow settings, down-counter and registered outputs.
  always_ff @(posedge clock) begin
    if (scen_reset) begin
      state_r      <= IDLE;
      prev_r       <= 1'b0;
      cnt_r        <= CNT_ZERO;
      width_sh_r   <= CNT_ZERO;
      holdoff_sh_r <= CNT_ZERO;
      trig_out     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      prev_r <= output_trigger;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            width_sh_r   <= width_cycles;
            holdoff_sh_r <= holdoff_cycles;
            busy         <= 1'b1;
            if (enter_pulse_s) begin
              state_r  <= PULSE;
              cnt_r    <= last_pulse_index(width_cycles);
              trig_out <= 1'b1;
            end else begin
              state_r <= DELAY;
              cnt_r   <= delay_cycles - CNT_ONE;
            end
          end
        end
        DELAY: begin
          if (enter_pulse_s) begin
            state_r  <= PULSE;
            cnt_r    <= last_pulse_index(width_sh_r);
            trig_out <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        PULSE: begin
          if (cnt_r == CNT_ZERO) begin
            trig_out <= 1'b0;
            if (holdoff_sh_r != CNT_ZERO) begin
              state_r <= HOLDOFF;
              cnt_r   <= holdoff_sh_r - CNT_ONE;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        HOLDOFF: begin
          if (cnt_r == CNT_ZERO) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= CNT_ZERO;
          trig_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Status counters; clear has priority over a coincident increment.
  always_ff @(posedge clock) begin
    if (scen_reset || count_clear) begin
      trig_count   <= {TRIG_CNT_W{1'b0}};
      missed_count <= {MISS_CNT_W{1'b0}};
    end else begin
      if (enter_pulse_s) begin
        trig_count <= trig_count + TRIG_ONE;
      end
      if (missed_s && (missed_count != MISS_MAX)) begin
        missed_count <= missed_count + MISS_ONE;
      end
    end
  end

endmodule

// File: tb/tb_trigger_pulse_shaper.sv
// Scoreboard bench for trigger_pulse_shaper: predicted pulses are queued at stimulus
// time from the edge-timing formulas and popped when the DUT's pulse ends.
module tb_trigger_pulse_shaper;

  localparam int MISS_W = 4;

  logic              clock;
  logic              rst;
  logic              en;
  logic              trig;
  logic [15:0]       dly;
  logic [15:0]       wid;
  logic [15:0]       hold;
  logic              clr;
  logic              trig_out;
  logic              busy;
  logic [31:0]       trig_count;
  logic [MISS_W-1:0] missed_count;

  trigger_pulse_shaper #(.CNT_W(16), .TRIG_CNT_W(32), .MISS_CNT_W(MISS_W)) dut (
    .clock          (clock),
    .scen_reset     (rst),
    .enable         (en),
    .output_trigger (trig),
    .delay_cycles   (dly),
    .width_cycles   (wid),
    .holdoff_cycles (hold),
    .count_clear    (clr),
    .trig_out       (trig_out),
    .busy           (busy),
    .trig_count     (trig_count),
    .missed_count   (missed_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int s;
    int e;
  } pulse_t;

  pulse_t            exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                edge_n = 0;
  bit                checks_on = 1'b0;
  bit                m_prev = 1'b0;
  logic [31:0]       m_trig = 32'd0;
  logic [MISS_W-1:0] m_miss = '0;
  int                m_rearm = 0;
  int                m_inc_edge = -1;
  int                m_busy_lo = 1;
  int                m_busy_hi = 0;
  int                m_pulses = 0;
  bit                mon_prev = 1'b0;
  int                mon_start = 0;
  int                pulses_seen = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_n, act, exp);
    end
  endtask

  // Advance the reference model by the clock edge edge_n with the current inputs.
  task automatic model_edge();
    int  d;
    int  w;
    int  h;
    bit  rise;
    bit  miss;
    if (rst) begin
      checks_on  = 1'b1;
      m_prev     = 1'b0;
      m_trig     = 32'd0;
      m_miss     = '0;
      m_rearm    = edge_n + 1;
      m_inc_edge = -1;
      if (m_busy_hi > edge_n) m_busy_hi = edge_n;
      if (exp_q.size() > 0) begin
        if (exp_q[0].s > edge_n) begin
          exp_q.delete(0);
          m_pulses--;
        end else if (exp_q[0].e > edge_n) begin
          exp_q[0].e = edge_n;
        end
      end
    end else begin
      rise   = trig && !m_prev;
      m_prev = trig;
      miss   = 1'b0;
      if (rise && en) begin
        if (edge_n >= m_rearm) begin
          d = int'(dly);
          w = (wid == 16'd0) ? 1 : int'(wid);
          h = int'(hold);
          exp_q.push_back('{s: edge_n + 1 + d, e: edge_n + d + w});
          m_pulses++;
          m_inc_edge = edge_n + d;
          m_rearm    = edge_n + d + w + h + 1;
          m_busy_lo  = edge_n + 1;
          m_busy_hi  = edge_n + d + w + h;
        end else begin
          miss = 1'b1;
        end
      end
      if (clr) begin
        m_trig = 32'd0;
        m_miss = '0;
      end else begin
        if (edge_n == m_inc_edge) m_trig = m_trig + 32'd1;
        if (miss && (m_miss != {MISS_W{1'b1}})) m_miss = m_miss + 1'b1;
      end
    end
  endtask

  // Compare the outputs visible at edge_n, update the model, then move to the next edge.
  task automatic step();
    logic exp_tout;
    if (checks_on) begin
      exp_tout = (exp_q.size() > 0) && (edge_n >= exp_q[0].s) && (edge_n <= exp_q[0].e);
      check_val("trig_out", {31'd0, trig_out}, {31'd0, exp_tout});
      check_val("busy", {31'd0, busy},
                ((edge_n >= m_busy_lo) && (edge_n <= m_busy_hi)) ? 32'd1 : 32'd0);
      check_val("trig_count", trig_count, m_trig);
      check_val("missed_count", {{(32-MISS_W){1'b0}}, missed_count}, {{(32-MISS_W){1'b0}}, m_miss});
      if (trig_out && !mon_prev) mon_start = edge_n;
      if (!trig_out && mon_prev) begin
        pulses_seen++;
        check_val("pulse_expected", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 32'd1);
        if (exp_q.size() > 0) begin
          check_val("pulse_start", mon_start, exp_q[0].s);
          check_val("pulse_end", edge_n - 1, exp_q[0].e);
          exp_q.delete(0);
        end
      end
      mon_prev = trig_out;
    end
    model_edge();
    @(negedge clock);
    edge_n++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    trig = 1'b0; en = 1'b1; rst = 1'b1; clr = 1'b0;
    dly = 16'd0; wid = 16'd1; hold = 16'd0;
    @(negedge clock);
    run(3); rst = 1'b0; run(5);

    // Basic delayed pulse: delay 3, width 2, no holdoff.
    dly = 16'd3; wid = 16'd2; hold = 16'd0;
    trig = 1'b1; run(1); trig = 1'b0; run(10);

    // Zero delay and zero width give a single-cycle pulse right away.
    dly = 16'd0; wid = 16'd0;
    trig = 1'b1; run(1); trig = 1'b0; run(5);

    // Holdoff: rise at N+6 is missed, rise at N+12 is accepted.
    dly = 16'd2; wid = 16'd4; hold = 16'd5;
    trig = 1'b1; run(1); trig = 1'b0; run(5);
    trig = 1'b1; run(1); trig = 1'b0; run(5);
    trig = 1'b1; run(1); trig = 1'b0; run(16);

    // Rise on the cycle the sequencer returns to idle counts as missed.
    trig = 1'b1; run(1); trig = 1'b0; run(10);
    trig = 1'b1; run(1); trig = 1'b0; run(1);
    trig = 1'b1; run(1); trig = 1'b0; run(16);

    // Changing delay mid-sequence affects only the next trigger.
    dly = 16'd3; wid = 16'd2; hold = 16'd0;
    trig = 1'b1; run(1); trig = 1'b0; dly = 16'd20; run(8);
    trig = 1'b1; run(1); trig = 1'b0; run(26);

    // Level held high gives one pulse; rises with enable low are ignored.
    dly = 16'd1; wid = 16'd2;
    trig = 1'b1; run(100); trig = 1'b0; run(3);
    en = 1'b0; trig = 1'b1; run(2); trig = 1'b0; run(3); en = 1'b1;

    // Dropping enable never truncates a running pulse.
    dly = 16'd0; wid = 16'd6; hold = 16'd2;
    trig = 1'b1; run(1); trig = 1'b0; run(2); en = 1'b0; run(8); en = 1'b1; run(2);

    // Reset in the middle of a pulse.
    dly = 16'd1; wid = 16'd10; hold = 16'd3;
    trig = 1'b1; run(1); trig = 1'b0; run(4); rst = 1'b1; run(1); rst = 1'b0; run(15);

    // Clear on the same edge as pulse entry leaves trig_count at zero.
    dly = 16'd2; wid = 16'd1; hold = 16'd0;
    trig = 1'b1; run(1); trig = 1'b0; run(1); clr = 1'b1; run(1); clr = 1'b0; run(5);

    // Burst of rises during a long holdoff saturates missed_count.
    dly = 16'd0; wid = 16'd1; hold = 16'd40;
    trig = 1'b1; run(1);
    repeat (20) begin
      trig = 1'b0; run(1); trig = 1'b1; run(1);
    end
    trig = 1'b0; run(45);

    // Random traffic with occasional clears, resets and setting changes.
    repeat (400) begin
      trig = ($urandom_range(2) == 0);
      en   = ($urandom_range(9) != 0);
      clr  = ($urandom_range(29) == 0);
      rst  = ($urandom_range(99) == 0);
      if ($urandom_range(15) == 0) begin
        dly  = 16'($urandom_range(6));
        wid  = 16'($urandom_range(5));
        hold = 16'($urandom_range(6));
      end
      run(1);
    end
    rst = 1'b0; clr = 1'b0; trig = 1'b0; en = 1'b1;
    run(40);

    check_val("queue_drained", exp_q.size(), 32'd0);
    check_val("pulse_total", pulses_seen, m_pulses);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_pulse_shaper.md
Name: trigger_pulse_shaper

Overview:
- Downstream stage of the scenario multiplexer.
- Consumes the multiplexer's output_trigger and turns each rising edge into a clean output pulse with programmable delay, width and holdoff.
- Keeps accepted-trigger and missed-trigger counters for status readback.
- Its output drives the physical synchronization output buffer.

Parameters:
- CNT_W, 16, width of delay/width/holdoff fields and of their internal down-counter.
- TRIG_CNT_W, 32, width of the accepted-trigger counter.
- MISS_CNT_W, 16, width of the missed-trigger counter.

Ports:
- clock  input  1  system clock (200 MHz)
- scen_reset  input  1  synchronous, active-high reset
- enable  input  1  1 = accept new trigger edges
- output_trigger  input  1  trigger from the scenario multiplexer; synchronous to clock
- delay_cycles  input  CNT_W  cycles from edge acceptance to pulse start
- width_cycles  input  CNT_W  pulse width in cycles; 0 is treated as 1
- holdoff_cycles  input  CNT_W  dead time after the pulse before re-arming
- count_clear  input  1  synchronous clear of both counters
- trig_out  output  1  shaped trigger pulse, registered
- busy  output  1  high in any state other than IDLE
- trig_count  output  TRIG_CNT_W  pulses issued; wraps at full scale
- missed_count  output  MISS_CNT_W  edges rejected while busy; saturates at all-ones

Behaviour:
- Clock and reset: one clock, `clock`. Reset is `scen_reset`, synchronous, active-high.
- Reset values: trig_out=0, busy=0, trig_count=0, missed_count=0, FSM=IDLE, edge-detect register=0, internal counter=0.
- Reset mid-operation: everything returns to reset values on the next clock edge. Any in-progress pulse is cut off. No counter update that cycle.
- Edge detect: rise = output_trigger & ~prev, where prev is output_trigger registered. A level held high yields exactly one rise.
- IDLE:
  - On rise & enable, latch delay, width and holdoff into shadow registers. Later input changes do not affect the running sequence.
  - If latched delay=0, go to PULSE; else go to DELAY with counter = delay−1.
- DELAY: decrement each cycle; at 0 go to PULSE with counter = max(width,1)−1.
- PULSE:
  - trig_out=1 for every cycle in this state; trig_out is a registered output of the state.
  - trig_count increments once, on the cycle the FSM enters PULSE.
  - At counter 0: go to HOLDOFF if holdoff≠0 (counter = holdoff−1), else go to IDLE.
- HOLDOFF: decrement; at 0 go to IDLE.
- Latency: rise sampled on clock edge N (input high at N, low at N−1) gives trig_out high from edge N+1+D through N+D+W inclusive, where W=max(width,1).
- Re-arm: earliest next accepted rise is at edge N+D+W+H+1.
- Missed triggers: a rise while the FSM is not IDLE and enable=1 increments missed_count (saturating). A rise in the same cycle the FSM returns to IDLE counts as missed.
- enable=0:
  - Rises are ignored and counted nowhere.
  - A running sequence always completes.
  - Deasserting enable never truncates a pulse.
- count_clear:
  - Zeroes both counters on the next edge.
  - If it coincides with an increment, clear wins and the counter reads 0.
  - count_clear does not affect the FSM or trig_out.
- busy = (state ≠ IDLE), registered alongside the state.

Test Plan:
- Reset, enable=1, delay=3, width=2, holdoff=0; single rise at edge 10 -> trig_out high at edges 14–15 only, busy high 11–15, trig_count=1, missed_count=0.
- delay=0, width=0 -> trig_out high for exactly one cycle at edge N+1; trig_count increments by 1.
- delay=2, width=4, holdoff=5; second rise 6 cycles after the first -> missed_count=1, one pulse only. Third rise at N+D+W+H+1=N+12 -> accepted, trig_count=2.
- Change delay_cycles from 3 to 20 during DELAY -> current pulse still starts at N+4. The next trigger uses 20.
- output_trigger held high for 100 cycles with enable=1 -> exactly one pulse, missed_count=0. enable=0 during a rise -> no pulse, no count change.
- Assert scen_reset during PULSE -> trig_out=0 and busy=0 the next cycle, both counters 0. count_clear coincident with a PULSE entry -> trig_count=0.
